// File: rtl/inst_fetch_queue.sv
// Instruction memory with a host load port, a free-running sequential fetch engine,
// and a small prefetch FIFO of {word, pc} pairs feeding the IF stage.
module inst_fetch_queue #(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH      = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    localparam int         AW         = $clog2(DEPTH),
    localparam int         CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [31:0]       inst_pc,
    output logic [CW-1:0]     fifo_count
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'd4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    logic [31:0]       fetch_pc_reg;
    logic [31:0]       tag_pc_reg;
    logic              inflight_reg;
    logic              oob_reg;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [31:0]       fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    logic [CW:0]       occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Entries already buffered plus the one read in flight must leave room,
    // so a returning read can never find the FIFO full.
    assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign issue     = fetch_en && !load_en && !redirect_valid
                       && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign push      = inflight_reg && !redirect_valid;
    assign pop       = (count_reg != '0) && inst_ready && !redirect_valid;

    // Program RAM: no reset so it maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (issue) begin
            rd_data_reg <= mem[fetch_pc_reg[AW+1:2]];
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= oob_reg ? '0 : rd_data_reg;
            fifo_pc[wr_ptr_reg]   <= tag_pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            tag_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            oob_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
                tag_pc_reg   <= fetch_pc_reg;
                oob_reg      <= ({1'b0, fetch_pc_reg} >= MEM_BYTES);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign inst_valid = (count_reg != '0);
    assign inst       = inst_valid ? fifo_data[rd_ptr_reg] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr_reg] : '0;
    assign fifo_count = count_reg;

endmodule
